obstacle_pool_control: RTL
==========================

OBSTACLE_POOL_CONTROL -- requirements
Module: obstacle_pool_control

Interface
REQ-001 SHALL have parameter NUM_OBS, default 3, meaning number of obstacle slots, legal range 1-4.
REQ-002 SHALL have parameter OBS_W, default 10'd30, meaning obstacle width in pixels.
REQ-003 SHALL have parameter OBS_H, default 10'd30, meaning obstacle height in pixels.
REQ-004 SHALL have parameter X_SPEED, default 10'd5, meaning leftward pixels per tick.
REQ-005 SHALL have parameter Y_STEP, default 10'd3, meaning vertical pixels per tick.
REQ-006 SHALL have parameter Y_INIT, default 10'd50, meaning spawn offset above ground.
REQ-007 SHALL have parameter Y_BASELINE, default 10'd315, meaning ground line; Y_MIN_START = Y_BASELINE - OBS_H.
REQ-008 SHALL have parameter X_START, default 10'd640, meaning off-screen spawn x.
REQ-009 SHALL have parameter SPAWN_GAP, default 40, meaning ticks between spawns, minimum 1.
REQ-010 SHALL have port clk, input, 1 bit, 50 MHz clock.
REQ-011 SHALL have port rst, input, 1 bit, reset; rst is asynchronous, active-low; clock is clk.
REQ-012 SHALL have port game_en, input, 1 bit, tick enable.
REQ-013 SHALL have port collision, input, NUM_OBS bits, per-slot hit.
REQ-014 SHALL have port y_amplitude_in, input, 10 bits, extra arc height.
REQ-015 SHALL have port mode_in, input, 2 bits: 00 arc, 01 ground, 10 high, 11 arc.
REQ-016 SHALL have port obs_active, output, NUM_OBS bits, slot-live flags.
REQ-017 SHALL have port obs_x_flat, output, 10*NUM_OBS bits, slot i at [10i+9:10i].
REQ-018 SHALL have port obs_y_flat, output, 10*NUM_OBS bits, same packing.
REQ-019 SHALL have ports obstacle_width and obstacle_height, output, 10 bits each, constants OBS_W and OBS_H.
REQ-020 SHALL have port spawn_pulse, output, 1 bit, high for one clk after a spawn.
REQ-021 SHALL have port passed_count, output, 8 bits, obstacles that exited left.

Function
REQ-022 SHALL change state only on rising clk with game_en=1 (a "tick"); game_en=0 holds everything except spawn_pulse, which clears.
REQ-023 SHALL run a spawn counter 0..SPAWN_GAP-1: +1 per tick; at SPAWN_GAP-1 with an idle slot, spawn and clear to 0; at SPAWN_GAP-1 with no idle slot, hold (saturate).
REQ-024 SHALL spawn into the lowest-index slot idle at tick start; one spawn per tick maximum.
REQ-025 SHALL on spawn latch mode_in and y_amplitude_in into the slot and set x=X_START; state ASCEND (arc), FLAT_LO (ground), or FLAT_HI (high).
REQ-026 SHALL set spawn y_offset: Y_INIT for arc; 0 for ground; min(Y_INIT+amp, Y_MIN_START) for high.
REQ-027 SHALL compute peak = min(Y_INIT+amp_latched, Y_MIN_START) using 11-bit add.
REQ-028 SHALL in ASCEND: if y_offset+Y_STEP >= peak, set y_offset=peak and go to DESCEND, else y_offset += Y_STEP.
REQ-029 SHALL in DESCEND: if y_offset <= Y_STEP, despawn (arc complete), else y_offset -= Y_STEP.
REQ-030 SHALL move every live slot x -= X_SPEED each tick it does not despawn.
REQ-031 SHALL despawn priority per live slot: collision[i], then x <= X_SPEED (left exit, passed_count +1, saturating at 255), then arc complete.
REQ-032 SHALL ignore collision[i] for idle slots; a slot despawned this tick is not spawnable until the next tick.
REQ-033 SHALL output idle slots as x=X_START, y=Y_MIN_START; live y = Y_MIN_START - y_offset, combinational from registered state.

Reset
REQ-034 SHALL on rst=0 immediately: all slots IDLE, y_offset 0, counter 0, obs_active 0, spawn_pulse 0, passed_count 0.
REQ-035 SHALL discard in-flight obstacles on mid-game reset; no passed_count change.

Verification
REQ-036 Reset, game_en=1 continuously -> on 40th tick spawn_pulse=1, obs_active=001, x0=640, y0=235; next tick x0=635, y0=232.
REQ-037 Arc mode, amp=0 -> offset 50 then DESCEND 47..5,2; slot0 idle on the tick after offset 2, passed_count=0.
REQ-038 Ground mode -> y0=285 constant; x reaches 5 after 127 moves; next tick idle, passed_count=1.
REQ-039 collision=001 for one tick while slot0 live -> obs_active[0]=0 next edge, passed_count unchanged; collision=010 while slot1 idle -> no effect.
REQ-040 SPAWN_GAP=1, ground mode, all 3 slots live -> counter holds 0, no spawn_pulse; first slot freed -> spawn into it one tick later.
REQ-041 High mode, amp=600 -> y_offset clamps 285, y=0; game_en=0 for 10 clks -> outputs frozen; rst pulse mid-flight -> all outputs at reset values.

Source files
------------

// File: rtl/obstacle_pool_control.sv
// Obstacle pool: spawns obstacles on a fixed tick gap into free slots, moves them left,
// runs the per-slot vertical motion profile and despawns on hit, left exit or arc end.
module obstacle_pool_control #(
    parameter int          NUM_OBS    = 3,
    parameter logic [9:0]  OBS_W      = 10'd30,
    parameter logic [9:0]  OBS_H      = 10'd30,
    parameter logic [9:0]  X_SPEED    = 10'd5,
    parameter logic [9:0]  Y_STEP     = 10'd3,
    parameter logic [9:0]  Y_INIT     = 10'd50,
    parameter logic [9:0]  Y_BASELINE = 10'd315,
    parameter logic [9:0]  X_START    = 10'd640,
    parameter int          SPAWN_GAP  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    game_en,
    input  logic [NUM_OBS-1:0]      collision,
    input  logic [9:0]              y_amplitude_in,
    input  logic [1:0]              mode_in,
    output logic [NUM_OBS-1:0]      obs_active,
    output logic [10*NUM_OBS-1:0]   obs_x_flat,
    output logic [10*NUM_OBS-1:0]   obs_y_flat,
    output logic [9:0]              obstacle_width,
    output logic [9:0]              obstacle_height,
    output logic                    spawn_pulse,
    output logic [7:0]              passed_count
);
    localparam int unsigned CW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_GAP - 1);
    localparam logic [9:0] Y_MIN_START = Y_BASELINE - OBS_H;

    typedef enum logic [2:0] {
        S_IDLE, S_ASCEND, S_DESCEND, S_FLAT_LO, S_FLAT_HI
    } slot_state_t;

    slot_state_t        state      [NUM_OBS];
    slot_state_t        state_next [NUM_OBS];
    logic [9:0]         x_pos      [NUM_OBS];
    logic [9:0]         x_next     [NUM_OBS];
    logic [9:0]         y_off      [NUM_OBS];
    logic [9:0]         y_off_next [NUM_OBS];
    logic [9:0]         amp        [NUM_OBS];
    logic [9:0]         amp_next   [NUM_OBS];
    logic [CW-1:0]      cnt, cnt_next;
    logic               pulse_next;
    logic [7:0]         passed_next;
    logic [NUM_OBS-1:0] active_next;
    logic [NUM_OBS-1:0] take;
    logic               taken;
    logic               do_spawn;
    logic [2:0]         exits;
    logic [8:0]         psum;

    // Arc peak / high-mode offset, clamped so the obstacle never rises above the screen top.
    function automatic logic [9:0] peak_of(input logic [9:0] a);
        logic [10:0] sum;
        sum = {1'b0, Y_INIT} + {1'b0, a};
        return (sum >= {1'b0, Y_MIN_START}) ? Y_MIN_START : sum[9:0];
    endfunction

    assign obstacle_width  = OBS_W;
    assign obstacle_height = OBS_H;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                state[i] <= S_IDLE;
                x_pos[i] <= X_START;
                y_off[i] <= '0;
                amp[i]   <= '0;
            end
            cnt          <= '0;
            spawn_pulse  <= 1'b0;
            passed_count <= '0;
            obs_active   <= '0;
        end else begin
            state        <= state_next;
            x_pos        <= x_next;
            y_off        <= y_off_next;
            amp          <= amp_next;
            cnt          <= cnt_next;
            spawn_pulse  <= pulse_next;
            passed_count <= passed_next;
            obs_active   <= active_next;
        end
    end

    always_comb begin
        state_next  = state;
        x_next      = x_pos;
        y_off_next  = y_off;
        amp_next    = amp;
        cnt_next    = cnt;
        pulse_next  = 1'b0;
        passed_next = passed_count;
        active_next = obs_active;
        take        = '0;
        taken       = 1'b0;
        do_spawn    = 1'b0;
        exits       = '0;
        psum        = '0;

        // Lowest-index slot idle at the start of the tick.
        for (int i = 0; i < NUM_OBS; i++) begin
            if (state[i] == S_IDLE && !taken) begin
                take[i] = 1'b1;
                taken   = 1'b1;
            end
        end

        if (game_en) begin
            if (cnt == CNT_LAST) begin
                do_spawn = taken;
                if (taken) cnt_next = '0;
            end else begin
                cnt_next = cnt + CW'(1);
            end
            pulse_next = do_spawn;

            for (int i = 0; i < NUM_OBS; i++) begin
                if (state[i] == S_IDLE) begin
                    if (do_spawn && take[i]) begin
                        amp_next[i] = y_amplitude_in;
                        x_next[i]   = X_START;
                        case (mode_in)
                            2'b01: begin
                                state_next[i] = S_FLAT_LO;
                                y_off_next[i] = '0;
                            end
                            2'b10: begin
                                state_next[i] = S_FLAT_HI;
                                y_off_next[i] = peak_of(y_amplitude_in);
                            end
                            default: begin
                                state_next[i] = S_ASCEND;
                                y_off_next[i] = Y_INIT;
                            end
                        endcase
                    end
                end else if (collision[i] || x_pos[i] <= X_SPEED
                             || (state[i] == S_DESCEND && y_off[i] <= Y_STEP)) begin
                    // Hit beats left exit, so a hit on the last step is not counted as passed.
                    if (!collision[i] && x_pos[i] <= X_SPEED) exits = exits + 3'd1;
                    state_next[i] = S_IDLE;
                    x_next[i]     = X_START;
                    y_off_next[i] = '0;
                end else begin
                    x_next[i] = x_pos[i] - X_SPEED;
                    case (state[i])
                        S_ASCEND: begin
                            if ({1'b0, y_off[i]} + {1'b0, Y_STEP} >= {1'b0, peak_of(amp[i])}) begin
                                y_off_next[i] = peak_of(amp[i]);
                                state_next[i] = S_DESCEND;
                            end else begin
                                y_off_next[i] = y_off[i] + Y_STEP;
                            end
                        end
                        S_DESCEND: y_off_next[i] = y_off[i] - Y_STEP;
                        default: ;
                    endcase
                end
            end

            psum        = {1'b0, passed_count} + 9'(exits);
            passed_next = (psum > 9'd255) ? 8'hFF : psum[7:0];
            for (int i = 0; i < NUM_OBS; i++) begin
                active_next[i] = (state_next[i] != S_IDLE);
            end
        end
    end

    // Idle slots park off-screen on the ground line.
    always_comb begin
        obs_x_flat = '0;
        obs_y_flat = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            obs_x_flat[10*i +: 10] = (state[i] == S_IDLE) ? X_START : x_pos[i];
            obs_y_flat[10*i +: 10] = (state[i] == S_IDLE) ? Y_MIN_START
                                                           : Y_MIN_START - y_off[i];
        end
    end
endmodule
